axi_lite_slave_regs: RTL and testbench
======================================

Name: axi_lite_slave_regs

Overview:
- AXI4-Lite responder (slave) holding a bank of NUM_REGS 32-bit control/status registers.
- Accepts write address and write data independently, applies byte strobes, and returns a write response.
- Serves single-beat reads.
- Pairs with the team's AXI-Lite master; the register contents are exported flat for use by the surrounding system logic.

Parameters:
- NUM_REGS, 8, number of 32-bit registers (power of two, 2..256); register i is at byte address 4*i.
- RESET_VALUE, 32'h0000_0000, value loaded into every register on reset.

Ports:
- ACLK  in  1  single clock; all logic on the rising edge.
- ARESET  in  1  reset, synchronous, active-high.
- AWVALID  in  1  write address valid.
- AWREADY  out  1  write address ready.
- AWADDR  in  32  write byte address.
- WVALID  in  1  write data valid.
- WREADY  out  1  write data ready.
- WDATA  in  32  write data.
- WSTRB  in  4  byte enables; bit n enables WDATA[8n+7:8n].
- BVALID  out  1  write response valid.
- BREADY  in  1  write response ready.
- BRESP  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR.
- ARVALID  in  1  read address valid.
- ARREADY  out  1  read address ready.
- ARADDR  in  32  read byte address.
- RVALID  out  1  read data valid.
- RREADY  in  1  read data ready.
- RDATA  out  32  read data.
- RRESP  out  2  read response: 2'b00 OKAY, 2'b10 SLVERR.
- REG_FLAT  out  32*NUM_REGS  register contents; register i on bits [32i+31:32i].

Behaviour:
- Clock and reset:
  - One clock, ACLK. Reset is ARESET, synchronous and active-high.
  - While ARESET=1: all registers = RESET_VALUE; BVALID=RVALID=0; BRESP=RRESP=0; RDATA=0; AWREADY=WREADY=ARREADY=0; internal AW/W capture flags cleared.
  - Reset asserted mid-transaction discards it; no B or R response is ever issued for it.
- Address decode:
  - Index = ADDR[log2(NUM_REGS)+1:2]. ADDR[1:0] are ignored.
  - An address is in range iff ADDR[31:2] < NUM_REGS.
- Write path (states W_IDLE, W_RESP):
  - AWREADY = !ARESET && !aw_held && !BVALID.
  - WREADY = !ARESET && !w_held && !BVALID.
  - AW and W handshakes may occur in either order or in the same cycle. Each captures its address or data+strobe and sets its held flag.
  - On the edge where both are available (held or handshaking that edge):
    - In range: each byte with a set WSTRB bit is written; other bytes are kept. BRESP=OKAY.
    - Out of range: no register changes. BRESP=SLVERR.
    - WSTRB=4'b0000 with an in-range address: no change, BRESP=OKAY.
    - At that same edge: held flags clear, BVALID=1, state goes to W_RESP.
  - BVALID is asserted in the cycle after the last of the two handshakes; REG_FLAT shows the new value in that same cycle.
  - W_RESP: BVALID and BRESP are stable until BVALID&&BREADY. On that edge BVALID=0 and the state returns to W_IDLE; AW/W can be accepted again from the next cycle.
  - Maximum throughput: one write every 2 cycles.
- Read path (states R_IDLE, R_DATA):
  - ARREADY = !ARESET && !RVALID.
  - On the ARVALID&&ARREADY edge: RDATA = register[index], RRESP=OKAY when in range; RDATA=0, RRESP=SLVERR when out of range. RVALID=1 from the next cycle.
  - R_DATA: RDATA, RRESP and RVALID are held stable until RVALID&&RREADY. On that edge RVALID=0.
  - Maximum throughput: one read every 2 cycles.
- Simultaneous events:
  - A read and a write committing on the same edge to the same register: the read returns the pre-write value.
  - Read and write paths are fully independent; neither stalls the other.
- Backpressure: holding BREADY=0 or RREADY=0 indefinitely is legal. The corresponding outputs must not change and no new transaction may be accepted on that channel.

Test Plan:
- Reset, then AW 0x04 and W 0xDEADBEEF/4'hF in the same cycle, BREADY=1 -> BVALID next cycle with BRESP=00; REG_FLAT[63:32]=0xDEADBEEF; AR 0x04 -> RVALID next cycle, RDATA=0xDEADBEEF, RRESP=00.
- W first (0x11223344, strobe 4'b0101) then AW 0x08 three cycles later, onto register 2 = 0xAABBCCDD -> no BVALID until the AW handshake; register 2 becomes 0xAA22CC44; AWREADY=0 and WREADY=0 while BVALID pending.
- Write and read to address 0x40 with NUM_REGS=8 -> BRESP=10, no register changed; RDATA=0, RRESP=10.
- RREADY held low 5 cycles after a read of register 0 -> RVALID/RDATA stable, ARREADY=0 throughout; a second AR is accepted only after the R handshake.
- Same-edge read and write of register 3 (old 0x1, new 0x2) -> RDATA=0x1; subsequent read returns 0x2.
- ARESET pulsed while BVALID=1 and a read is pending -> next cycle BVALID=RVALID=0, all registers = RESET_VALUE, no stale response after release.

Source files
------------

// File: rtl/axi_lite_slave_regs.sv
// ---------------------------------------------------------------------------
// axi_lite_slave_regs
//
// AXI4-Lite responder that holds a bank of NUM_REGS 32-bit control/status
// registers. Register i is at byte address 4*i. The whole bank is also
// exported flat so the surrounding system logic can use it directly.
//
// Ports
//   ACLK, ARESET             clock and synchronous active-high reset
//   AWVALID/AWREADY/AWADDR   write address channel
//   WVALID/WREADY/WDATA/WSTRB write data channel (byte strobes)
//   BVALID/BREADY/BRESP      write response channel (OKAY / SLVERR)
//   ARVALID/ARREADY/ARADDR   read address channel
//   RVALID/RREADY/RDATA/RRESP read data channel (OKAY / SLVERR)
//   REG_FLAT                 register i on bits [32i+31:32i]
// ---------------------------------------------------------------------------
module axi_lite_slave_regs #(
    parameter int          NUM_REGS    = 8,
    parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [31:0]             AWADDR,
    input  logic                    WVALID,
    output logic                    WREADY,
    input  logic [31:0]             WDATA,
    input  logic [3:0]              WSTRB,
    output logic                    BVALID,
    input  logic                    BREADY,
    output logic [1:0]              BRESP,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    input  logic [31:0]             ARADDR,
    output logic                    RVALID,
    input  logic                    RREADY,
    output logic [31:0]             RDATA,
    output logic [1:0]              RRESP,
    output logic [32*NUM_REGS-1:0]  REG_FLAT
);

    localparam int IDXW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} wState_t;
    typedef enum logic {R_IDLE, R_DATA} rState_t;

    // Register bank
    logic [NUM_REGS-1:0][31:0] r_regs;

    // Write channel state
    wState_t      r_wState;
    wState_t      w_wStateNext;
    logic         r_awHeld;
    logic         r_wHeld;
    logic [31:2]  r_awAddr;
    logic [31:0]  r_wData;
    logic [3:0]   r_wStrb;
    logic [1:0]   r_bResp;

    // Read channel state
    rState_t      r_rState;
    rState_t      w_rStateNext;
    logic [31:0]  r_rData;
    logic [1:0]   r_rResp;

    // Combinational helpers
    logic         w_awFire;
    logic         w_wFire;
    logic         w_arFire;
    logic         w_commit;
    logic [31:2]  w_wrAddr;
    logic [31:0]  w_wrData;
    logic [3:0]   w_wrStrb;
    logic [IDXW-1:0] w_wrIdx;
    logic         w_wrInRange;
    logic [IDXW-1:0] w_rdIdx;
    logic         w_rdInRange;
    logic         w_unusedAddrBits;

    // The two low address bits only select a byte within a word, which this
    // bank never needs; they are folded here so they are visibly consumed.
    assign w_unusedAddrBits = ^{AWADDR[1:0], ARADDR[1:0]};

    assign BVALID   = (r_wState == W_RESP);
    assign RVALID   = (r_rState == R_DATA);
    assign AWREADY  = !ARESET && !r_awHeld && !BVALID;
    assign WREADY   = !ARESET && !r_wHeld && !BVALID;
    assign ARREADY  = !ARESET && !RVALID;
    assign BRESP    = r_bResp;
    assign RDATA    = r_rData;
    assign RRESP    = r_rResp;
    assign REG_FLAT = r_regs;

    assign w_awFire = AWVALID && AWREADY;
    assign w_wFire  = WVALID && WREADY;
    assign w_arFire = ARVALID && ARREADY;

    // A held beat takes priority over the bus because the bus value belongs
    // to a channel that is no longer being listened to once its flag is set.
    assign w_wrAddr = r_awHeld ? r_awAddr : AWADDR[31:2];
    assign w_wrData = r_wHeld  ? r_wData  : WDATA;
    assign w_wrStrb = r_wHeld  ? r_wStrb  : WSTRB;
    assign w_wrIdx  = w_wrAddr[IDXW+1:2];
    assign w_wrInRange = (32'(w_wrAddr) < 32'(NUM_REGS));

    assign w_rdIdx     = ARADDR[IDXW+1:2];
    assign w_rdInRange = (32'(ARADDR[31:2]) < 32'(NUM_REGS));

    // The write commits on the first edge where both address and data are
    // available, whether they arrived earlier (held) or are arriving now.
    assign w_commit = (r_wState == W_IDLE) &&
                      (r_awHeld || w_awFire) &&
                      (r_wHeld  || w_wFire);

    // Write FSM state register.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_wState <= W_IDLE;
        end else begin
            r_wState <= w_wStateNext;
        end
    end

    // Write FSM next state: leave idle on commit, return once B is taken.
    always_comb begin
        w_wStateNext = r_wState;
        case (r_wState)
            W_IDLE:  if (w_commit) w_wStateNext = W_RESP;
            W_RESP:  if (BREADY)   w_wStateNext = W_IDLE;
            default: w_wStateNext = W_IDLE;
        endcase
    end

    // Capture of address and data beats that arrive ahead of their partner,
    // plus the write response code chosen at commit time.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_awHeld <= 1'b0;
            r_wHeld  <= 1'b0;
            r_awAddr <= '0;
            r_wData  <= '0;
            r_wStrb  <= '0;
            r_bResp  <= RESP_OKAY;
        end else if (w_commit) begin
            r_awHeld <= 1'b0;
            r_wHeld  <= 1'b0;
            r_bResp  <= w_wrInRange ? RESP_OKAY : RESP_SLVERR;
        end else begin
            if (w_awFire) begin
                r_awHeld <= 1'b1;
                r_awAddr <= AWADDR[31:2];
            end
            if (w_wFire) begin
                r_wHeld <= 1'b1;
                r_wData <= WDATA;
                r_wStrb <= WSTRB;
            end
        end
    end

    // Register bank update: only strobed bytes of an in-range target change.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_regs <= {NUM_REGS{RESET_VALUE}};
        end else if (w_commit && w_wrInRange) begin
            for (int b = 0; b < 4; b++) begin
                if (w_wrStrb[b]) begin
                    r_regs[w_wrIdx][8*b +: 8] <= w_wrData[8*b +: 8];
                end
            end
        end
    end

    // Read FSM state register.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_rState <= R_IDLE;
        end else begin
            r_rState <= w_rStateNext;
        end
    end

    // Read FSM next state: one outstanding read, released by the R handshake.
    always_comb begin
        w_rStateNext = r_rState;
        case (r_rState)
            R_IDLE:  if (w_arFire) w_rStateNext = R_DATA;
            R_DATA:  if (RREADY)   w_rStateNext = R_IDLE;
            default: w_rStateNext = R_IDLE;
        endcase
    end

    // Read data capture. r_regs is sampled before any same-edge write lands,
    // so a colliding read returns the old contents.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_rData <= '0;
            r_rResp <= RESP_OKAY;
        end else if (w_arFire) begin
            r_rData <= w_rdInRange ? r_regs[w_rdIdx] : 32'h0;
            r_rResp <= w_rdInRange ? RESP_OKAY : RESP_SLVERR;
        end
    end

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_slave_regs
//
// Directed bench for axi_lite_slave_regs (NUM_REGS = 8, RESET_VALUE = 0).
// Inputs change 1 ns after each rising edge; outputs are checked at that
// same point, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_axi_lite_slave_regs;

    logic          ACLK;
    logic          ARESET;
    logic          AWVALID;
    logic          AWREADY;
    logic [31:0]   AWADDR;
    logic          WVALID;
    logic          WREADY;
    logic [31:0]   WDATA;
    logic [3:0]    WSTRB;
    logic          BVALID;
    logic          BREADY;
    logic [1:0]    BRESP;
    logic          ARVALID;
    logic          ARREADY;
    logic [31:0]   ARADDR;
    logic          RVALID;
    logic          RREADY;
    logic [31:0]   RDATA;
    logic [1:0]    RRESP;
    logic [255:0]  REG_FLAT;

    logic [7:0][31:0] expRegs;
    int nAsserts;
    int nFailures;

    axi_lite_slave_regs #(
        .NUM_REGS    (8),
        .RESET_VALUE (32'h0000_0000)
    ) dut (
        .ACLK     (ACLK),
        .ARESET   (ARESET),
        .AWVALID  (AWVALID),
        .AWREADY  (AWREADY),
        .AWADDR   (AWADDR),
        .WVALID   (WVALID),
        .WREADY   (WREADY),
        .WDATA    (WDATA),
        .WSTRB    (WSTRB),
        .BVALID   (BVALID),
        .BREADY   (BREADY),
        .BRESP    (BRESP),
        .ARVALID  (ARVALID),
        .ARREADY  (ARREADY),
        .ARADDR   (ARADDR),
        .RVALID   (RVALID),
        .RREADY   (RREADY),
        .RDATA    (RDATA),
        .RRESP    (RRESP),
        .REG_FLAT (REG_FLAT)
    );

    // 100 MHz clock
    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    // Advance to 1 ns past the next rising edge.
    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // Drive every handshake input in one go.
    task automatic applyStimulus(
        input logic        awv, input logic [31:0] awa,
        input logic        wv,  input logic [31:0] wd, input logic [3:0] ws,
        input logic        br,
        input logic        arv, input logic [31:0] ara,
        input logic        rr
    );
        AWVALID = awv;
        AWADDR  = awa;
        WVALID  = wv;
        WDATA   = wd;
        WSTRB   = ws;
        BREADY  = br;
        ARVALID = arv;
        ARADDR  = ara;
        RREADY  = rr;
    endtask

    // One comparison: count it, and report it if it does not hold.
    task automatic checkOutput(input string tag, input logic [255:0] obs,
                               input logic [255:0] exp);
        nAsserts++;
        assert (obs === exp)
        else begin
            nFailures++;
            $error("[TB] FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
        end
    endtask

    // Write with AW and W in the same cycle and BREADY high; checks the
    // response the next cycle and the bank against expRegs.
    task automatic writeBoth(input string tag, input logic [31:0] addr,
                             input logic [31:0] data, input logic [3:0] strb,
                             input logic [1:0] expResp);
        applyStimulus(1'b1, addr, 1'b1, data, strb, 1'b1, 1'b0, 32'h0, 1'b1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput({tag, "_bvalid"}, 256'(BVALID), 256'(1'b1));
        checkOutput({tag, "_bresp"},  256'(BRESP),  256'(expResp));
        checkOutput({tag, "_regs"},   REG_FLAT,     expRegs);
        tick();
        checkOutput({tag, "_bdone"},  256'(BVALID), 256'(1'b0));
    endtask

    // Single read with RREADY high.
    task automatic readCheck(input string tag, input logic [31:0] addr,
                             input logic [31:0] expData, input logic [1:0] expResp);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b1, addr, 1'b1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput({tag, "_rvalid"}, 256'(RVALID), 256'(1'b1));
        checkOutput({tag, "_rdata"},  256'(RDATA),  256'(expData));
        checkOutput({tag, "_rresp"},  256'(RRESP),  256'(expResp));
        tick();
        checkOutput({tag, "_rdone"},  256'(RVALID), 256'(1'b0));
    endtask

    // Directed sequence
    initial begin
        nAsserts  = 0;
        nFailures = 0;
        expRegs   = '0;
        ARESET    = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b0);

        // Reset state
        repeat (3) tick();
        checkOutput("rst_bvalid",  256'(BVALID),  256'(1'b0));
        checkOutput("rst_rvalid",  256'(RVALID),  256'(1'b0));
        checkOutput("rst_awready", 256'(AWREADY), 256'(1'b0));
        checkOutput("rst_wready",  256'(WREADY),  256'(1'b0));
        checkOutput("rst_arready", 256'(ARREADY), 256'(1'b0));
        checkOutput("rst_rdata",   256'(RDATA),   256'(32'h0));
        checkOutput("rst_regs",    REG_FLAT,      expRegs);
        ARESET = 1'b0;
        tick();
        checkOutput("idle_awready", 256'(AWREADY), 256'(1'b1));
        checkOutput("idle_wready",  256'(WREADY),  256'(1'b1));
        checkOutput("idle_arready", 256'(ARREADY), 256'(1'b1));

        // Same-cycle AW/W to register 1, then read it back
        $display("[TB] same-cycle write and read of 0x04");
        expRegs[1] = 32'hDEAD_BEEF;
        writeBoth("wr1", 32'h4, 32'hDEAD_BEEF, 4'hF, 2'b00);
        checkOutput("wr1_flat", 256'(REG_FLAT[63:32]), 256'(32'hDEAD_BEEF));
        readCheck("rd1", 32'h4, 32'hDEAD_BEEF, 2'b00);

        // Zero strobe: address in range, nothing changes, OKAY
        writeBoth("strb0", 32'h4, 32'hFFFF_FFFF, 4'h0, 2'b00);

        // W ahead of AW by three cycles, partial strobe, BREADY held low
        $display("[TB] W before AW onto register 2");
        expRegs[2] = 32'hAABB_CCDD;
        writeBoth("wr2init", 32'h8, 32'hAABB_CCDD, 4'hF, 2'b00);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h1122_3344, 4'b0101, 1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("wfirst_wready",  256'(WREADY),  256'(1'b0));
        checkOutput("wfirst_awready", 256'(AWREADY), 256'(1'b1));
        for (int i = 0; i < 3; i++) begin
            checkOutput("wfirst_nob", 256'(BVALID), 256'(1'b0));
            checkOutput("wfirst_reg", REG_FLAT,     expRegs);
            if (i < 2) tick();
        end
        applyStimulus(1'b1, 32'h8, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        expRegs[2] = 32'hAA22_CC44;
        checkOutput("wlate_bvalid", 256'(BVALID), 256'(1'b1));
        checkOutput("wlate_bresp",  256'(BRESP),  256'(2'b00));
        checkOutput("wlate_regs",   REG_FLAT,     expRegs);
        for (int i = 0; i < 2; i++) begin
            tick();
            checkOutput("bhold_bvalid",  256'(BVALID),  256'(1'b1));
            checkOutput("bhold_awready", 256'(AWREADY), 256'(1'b0));
            checkOutput("bhold_wready",  256'(WREADY),  256'(1'b0));
        end
        BREADY = 1'b1;
        tick();
        checkOutput("bhold_done", 256'(BVALID), 256'(1'b0));

        // Out-of-range write and read
        $display("[TB] out-of-range access at 0x40");
        writeBoth("wroor", 32'h40, 32'h1234_5678, 4'hF, 2'b10);
        readCheck("rdoor", 32'h40, 32'h0, 2'b10);

        // RREADY backpressure on a read of register 0; second AR must wait
        $display("[TB] read backpressure");
        expRegs[0] = 32'hCAFE_0001;
        writeBoth("wr0", 32'h0, 32'hCAFE_0001, 4'hF, 2'b00);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b1, 32'h0, 1'b0);
        tick();
        ARADDR = 32'h4;
        for (int i = 0; i < 5; i++) begin
            checkOutput("rbp_rvalid",  256'(RVALID),  256'(1'b1));
            checkOutput("rbp_rdata",   256'(RDATA),   256'(32'hCAFE_0001));
            checkOutput("rbp_arready", 256'(ARREADY), 256'(1'b0));
            tick();
        end
        RREADY = 1'b1;
        tick();
        checkOutput("rbp_released", 256'(RVALID),  256'(1'b0));
        checkOutput("rbp_arready2", 256'(ARREADY), 256'(1'b1));
        tick();
        ARVALID = 1'b0;
        checkOutput("rbp_second_rvalid", 256'(RVALID), 256'(1'b1));
        checkOutput("rbp_second_rdata",  256'(RDATA),  256'(32'hDEAD_BEEF));
        tick();
        checkOutput("rbp_second_done",   256'(RVALID), 256'(1'b0));

        // Same-edge read and write of register 3
        $display("[TB] read/write collision on register 3");
        expRegs[3] = 32'h1;
        writeBoth("wr3a", 32'hC, 32'h1, 4'hF, 2'b00);
        applyStimulus(1'b1, 32'hC, 1'b1, 32'h2, 4'hF, 1'b1, 1'b1, 32'hC, 1'b1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, 1'b1);
        expRegs[3] = 32'h2;
        checkOutput("coll_rvalid", 256'(RVALID), 256'(1'b1));
        checkOutput("coll_rdata",  256'(RDATA),  256'(32'h1));
        checkOutput("coll_bvalid", 256'(BVALID), 256'(1'b1));
        checkOutput("coll_regs",   REG_FLAT,     expRegs);
        tick();
        readCheck("coll_after", 32'hC, 32'h2, 2'b00);

        // Reset while both a B and an R response are pending
        $display("[TB] reset with responses pending");
        applyStimulus(1'b1, 32'h14, 1'b1, 32'h55, 4'hF, 1'b0, 1'b1, 32'hC, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        expRegs[5] = 32'h55;
        checkOutput("prerst_bvalid", 256'(BVALID), 256'(1'b1));
        checkOutput("prerst_rvalid", 256'(RVALID), 256'(1'b1));
        checkOutput("prerst_regs",   REG_FLAT,     expRegs);
        ARESET = 1'b1;
        tick();
        expRegs = '0;
        checkOutput("midrst_bvalid", 256'(BVALID), 256'(1'b0));
        checkOutput("midrst_rvalid", 256'(RVALID), 256'(1'b0));
        checkOutput("midrst_regs",   REG_FLAT,     expRegs);
        checkOutput("midrst_rdata",  256'(RDATA),  256'(32'h0));
        checkOutput("midrst_bresp",  256'(BRESP),  256'(2'b00));
        ARESET = 1'b0;
        BREADY = 1'b1;
        RREADY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("postrst_bvalid", 256'(BVALID), 256'(1'b0));
            checkOutput("postrst_rvalid", 256'(RVALID), 256'(1'b0));
        end

        // A held W beat must be forgotten by reset
        $display("[TB] held W discarded by reset");
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h99, 4'hF, 1'b1, 1'b0, 32'h0, 1'b1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput("held_wready", 256'(WREADY), 256'(1'b0));
        ARESET = 1'b1;
        tick();
        ARESET = 1'b0;
        applyStimulus(1'b1, 32'h8, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, 1'b1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput("held_nob",  256'(BVALID), 256'(1'b0));
        checkOutput("held_regs", REG_FLAT,     expRegs);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h77, 4'hF, 1'b1, 1'b0, 32'h0, 1'b1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, 1'b1);
        expRegs[2] = 32'h77;
        checkOutput("held_bvalid", 256'(BVALID), 256'(1'b1));
        checkOutput("held_wr",     REG_FLAT,     expRegs);
        tick();
        checkOutput("held_bdone",  256'(BVALID), 256'(1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFailures);
        $finish;
    end

endmodule
